// File: rtl/ex_mem_flag_reg.sv
// ex_mem_flag_reg: EX->MEM pipeline register with condition-code register and CCR save stack
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   stall, flush                 hold everything / squash incoming EX instruction
//   ex_*                         EX-stage result, flags, flag mask, SETC/CLRC, dest and control bits
//   int_push, rti_pop            save CCR on interrupt entry / restore CCR on RTI
//   mem_*                        latched MEM-stage copies of the EX outputs
//   ccr, ccr_fwd                 registered {C,S,Z} and its forwarded view
//   stack_full/empty/err         save-stack status, err sticky until reset
// Build option FLAG_BYPASS_EN: ccr_fwd is the combinational next-CCR instead of the registered ccr.
module ex_mem_flag_reg #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 3,
    parameter int STACK_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic [DATA_W-1:0]     ex_result_ext,
    input  logic                  ex_carry,
    input  logic                  ex_sign,
    input  logic                  ex_zero,
    input  logic [2:0]            ex_flag_mask,
    input  logic                  ex_setc,
    input  logic                  ex_clrc,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_rd,
    input  logic                  ex_mem_wr,
    input  logic                  int_push,
    input  logic                  rti_pop,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_result,
    output logic [DATA_W-1:0]     mem_result_ext,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_wb_en,
    output logic                  mem_mem_rd,
    output logic                  mem_mem_wr,
    output logic [2:0]            ccr,
    output logic [2:0]            ccr_fwd,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_err
);
    localparam int PW = $clog2(STACK_DEPTH + 1);

    logic                  r_valid, r_wb_en, r_mem_rd, r_mem_wr, r_err;
    logic [DATA_W-1:0]     r_result, r_result_ext;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [2:0]            r_ccr;
    logic [PW-1:0]         r_ptr;
    logic [2:0]            r_stack [STACK_DEPTH];

    logic       w_full, w_empty, w_push, w_pop, w_push_ok, w_pop_ok, w_take;
    logic [2:0] w_upd, w_upd_c, w_top, w_ccr_nxt;

    assign w_full    = r_ptr == PW'(STACK_DEPTH);
    assign w_empty   = r_ptr == '0;
    // simultaneous push and pop cancel each other out
    assign w_push    = int_push & ~rti_pop;
    assign w_pop     = rti_pop & ~int_push;
    assign w_push_ok = w_push & ~w_full;
    assign w_pop_ok  = w_pop & ~w_empty;
    assign w_take    = ex_valid & ~flush;
    assign w_upd     = (r_ccr & ~ex_flag_mask) | ({ex_carry, ex_sign, ex_zero} & ex_flag_mask);
    // CLRC beats SETC when both are set
    assign w_upd_c   = {ex_clrc ? 1'b0 : ex_setc ? 1'b1 : w_upd[2], w_upd[1:0]};

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (r_ptr == PW'(i + 1)) w_top = r_stack[i];
    end

    // a successful pop overrides the instruction's own flag update
    assign w_ccr_nxt = stall ? r_ccr : w_pop_ok ? w_top : w_take ? w_upd_c : r_ccr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_result_ext <= '0;
            r_rd         <= '0;
            r_wb_en      <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_ccr        <= '0;
            r_ptr        <= '0;
            r_err        <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else if (!stall) begin
            r_valid      <= w_take;
            r_result     <= flush ? '0 : ex_result;
            r_result_ext <= flush ? '0 : ex_result_ext;
            r_rd         <= flush ? '0 : ex_rd;
            r_wb_en      <= w_take & ex_wb_en;
            r_mem_rd     <= w_take & ex_mem_rd;
            r_mem_wr     <= w_take & ex_mem_wr;
            r_ccr        <= w_ccr_nxt;
            for (int i = 0; i < STACK_DEPTH; i++)
                if (w_push_ok && r_ptr == PW'(i)) r_stack[i] <= r_ccr;
            r_ptr        <= w_push_ok ? r_ptr + 1'b1 : w_pop_ok ? r_ptr - 1'b1 : r_ptr;
            r_err        <= r_err | (w_push & w_full) | (w_pop & w_empty);
        end
    end

    assign mem_valid      = r_valid;
    assign mem_result     = r_result;
    assign mem_result_ext = r_result_ext;
    assign mem_rd         = r_rd;
    assign mem_wb_en      = r_wb_en;
    assign mem_mem_rd     = r_mem_rd;
    assign mem_mem_wr     = r_mem_wr;
    assign ccr            = r_ccr;
    assign stack_full     = w_full;
    assign stack_empty    = w_empty;
    assign stack_err      = r_err;
`ifdef FLAG_BYPASS_EN
    assign ccr_fwd        = w_ccr_nxt;
`else
    assign ccr_fwd        = r_ccr;
`endif
endmodule

// File: tb/tb_ex_mem_flag_reg.sv
// tb_ex_mem_flag_reg: scoreboard bench for ex_mem_flag_reg with directed vectors
module tb_ex_mem_flag_reg;
    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid, ex_carry, ex_sign, ex_zero, ex_setc, ex_clrc;
    logic        ex_wb_en, ex_mem_rd, ex_mem_wr, int_push, rti_pop;
    logic [31:0] ex_result, ex_result_ext;
    logic [2:0]  ex_flag_mask, ex_rd;
    logic        mem_valid, mem_wb_en, mem_mem_rd, mem_mem_wr, stack_full, stack_empty, stack_err;
    logic [31:0] mem_result, mem_result_ext;
    logic [2:0]  mem_rd, ccr, ccr_fwd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic [31:0] ext;
        logic [2:0]  rd;
        logic [2:0]  ctl;
        logic [2:0]  ccr;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t last;

    ex_mem_flag_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_result(ex_result), .ex_result_ext(ex_result_ext),
        .ex_carry(ex_carry), .ex_sign(ex_sign), .ex_zero(ex_zero),
        .ex_flag_mask(ex_flag_mask), .ex_setc(ex_setc), .ex_clrc(ex_clrc), .ex_rd(ex_rd),
        .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .int_push(int_push), .rti_pop(rti_pop),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_result_ext(mem_result_ext),
        .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
        .ccr(ccr), .ccr_fwd(ccr_fwd),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle of stimulus; the expected post-edge state goes to the scoreboard
    task automatic step(input logic r, st, fl, v, input logic [31:0] res, ext,
                        input logic [2:0] flg, mask, input logic sc, cc,
                        input logic [2:0] rd, ctl, input logic pu, po,
                        input logic [2:0] eccr, input logic efull, eempty, eerr);
        exp_t e;
        @(negedge clk);
        rst = r; stall = st; flush = fl; ex_valid = v;
        ex_result = res; ex_result_ext = ext;
        {ex_carry, ex_sign, ex_zero} = flg;
        ex_flag_mask = mask; ex_setc = sc; ex_clrc = cc; ex_rd = rd;
        {ex_wb_en, ex_mem_rd, ex_mem_wr} = ctl;
        int_push = pu; rti_pop = po;
        e = '{default: '0};
        if (!r && st) e = last;
        else if (!r && !fl) begin
            e.v = v; e.res = res; e.ext = ext; e.rd = rd; e.ctl = v ? ctl : 3'b000;
        end
        e.ccr = eccr; e.full = efull; e.empty = eempty; e.err = eerr;
        last = e;
        q.push_back(e);
`ifdef FLAG_BYPASS_EN
        if (!r) begin
            #1;
            chk("ccr_fwd_bypass", {29'd0, ccr_fwd}, {29'd0, eccr});
        end
`endif
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("mem_valid", {31'd0, mem_valid}, {31'd0, e.v});
                chk("mem_result", mem_result, e.res);
                chk("mem_result_ext", mem_result_ext, e.ext);
                chk("mem_rd", {29'd0, mem_rd}, {29'd0, e.rd});
                chk("mem_ctl", {29'd0, mem_wb_en, mem_mem_rd, mem_mem_wr}, {29'd0, e.ctl});
                chk("ccr", {29'd0, ccr}, {29'd0, e.ccr});
`ifndef FLAG_BYPASS_EN
                chk("ccr_fwd", {29'd0, ccr_fwd}, {29'd0, e.ccr});
`endif
                chk("stack_full", {31'd0, stack_full}, {31'd0, e.full});
                chk("stack_empty", {31'd0, stack_empty}, {31'd0, e.empty});
                chk("stack_err", {31'd0, stack_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        last = '{default: '0};
        //   r st fl v  result         ext       flags   mask    sc cc rd    ctl     pu po  ccr     f  e  err
        step(1, 0, 0, 0, 32'h0,        32'h0,    3'b000, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0, 3'b000, 0, 1, 0);
        step(1, 0, 0, 0, 32'h0,        32'h0,    3'b000, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0, 3'b000, 0, 1, 0);
        step(0, 0, 0, 1, 32'habcc7b9d, 32'h0,    3'b110, 3'b111, 0, 0, 3'd5, 3'b101, 0, 0, 3'b110, 0, 1, 0);
        step(0, 1, 0, 1, 32'h1,        32'h2,    3'b001, 3'b001, 0, 1, 3'd2, 3'b111, 0, 0, 3'b110, 0, 1, 0);
        step(0, 0, 0, 1, 32'h1,        32'h2,    3'b001, 3'b001, 0, 1, 3'd2, 3'b111, 0, 0, 3'b011, 0, 1, 0);
        step(0, 0, 1, 1, 32'hdead,     32'hbeef, 3'b000, 3'b111, 0, 0, 3'd7, 3'b100, 0, 0, 3'b011, 0, 1, 0);
        step(0, 0, 0, 0, 32'h55,       32'h66,   3'b111, 3'b111, 1, 0, 3'd3, 3'b111, 0, 0, 3'b011, 0, 1, 0);
        step(0, 0, 0, 1, 32'h7,        32'h0,    3'b000, 3'b000, 1, 0, 3'd1, 3'b100, 0, 0, 3'b111, 0, 1, 0);
        step(0, 0, 0, 1, 32'h8,        32'h0,    3'b111, 3'b000, 1, 1, 3'd1, 3'b000, 0, 0, 3'b011, 0, 1, 0);
        step(0, 0, 0, 1, 32'h9,        32'h0,    3'b101, 3'b111, 0, 0, 3'd4, 3'b010, 0, 0, 3'b101, 0, 1, 0);
        step(0, 0, 0, 1, 32'ha,        32'h1,    3'b010, 3'b111, 0, 0, 3'd4, 3'b001, 1, 0, 3'b010, 0, 0, 0);
        step(0, 0, 0, 1, 32'hb,        32'h2,    3'b111, 3'b111, 0, 0, 3'd6, 3'b100, 0, 1, 3'b101, 0, 1, 0);
        step(0, 0, 0, 1, 32'hc,        32'h3,    3'b011, 3'b111, 0, 0, 3'd6, 3'b000, 1, 1, 3'b011, 0, 1, 0);
        step(0, 0, 0, 1, 32'hd,        32'h0,    3'b100, 3'b111, 0, 0, 3'd1, 3'b000, 1, 0, 3'b100, 0, 0, 0);
        step(0, 1, 0, 1, 32'he,        32'h0,    3'b111, 3'b111, 0, 0, 3'd1, 3'b000, 1, 0, 3'b100, 0, 0, 0);
        step(0, 0, 0, 1, 32'hf,        32'h0,    3'b001, 3'b111, 0, 0, 3'd2, 3'b000, 1, 0, 3'b001, 1, 0, 0);
        step(0, 0, 0, 0, 32'h10,       32'h0,    3'b000, 3'b000, 0, 0, 3'd0, 3'b000, 1, 0, 3'b001, 1, 0, 1);
        step(0, 0, 0, 0, 32'h11,       32'h0,    3'b000, 3'b000, 0, 0, 3'd0, 3'b000, 0, 1, 3'b100, 0, 0, 1);
        step(0, 0, 0, 1, 32'h12,       32'h0,    3'b111, 3'b111, 0, 0, 3'd3, 3'b010, 0, 1, 3'b011, 0, 1, 1);
        step(0, 0, 0, 1, 32'h13,       32'h0,    3'b100, 3'b100, 0, 0, 3'd3, 3'b000, 0, 1, 3'b111, 0, 1, 1);
        step(1, 0, 0, 1, 32'h14,       32'h5,    3'b111, 3'b111, 0, 0, 3'd7, 3'b111, 1, 0, 3'b000, 0, 1, 0);
        step(0, 0, 0, 1, 32'h15,       32'h0,    3'b001, 3'b111, 0, 0, 3'd2, 3'b110, 0, 0, 3'b001, 0, 1, 0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b1; int_push = 1'b0; rti_pop = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
